// File: rtl/instr_issue_unit_pkg.sv
// Shared constants and types for the instruction issue front end:
// opcode encodings, instruction-word field layout and scoreboard entry.
package instr_issue_unit_pkg;

    localparam int INSTR_W    = 20;
    localparam int OPCODE_W   = 2;
    localparam int REG_ADDR_W = 6;

    localparam int OPCODE_LSB = 18;
    localparam int DST_LSB    = 12;
    localparam int SRC1_LSB   = 6;
    localparam int SRC2_LSB   = 0;

    localparam logic [OPCODE_W-1:0] OP_ADD = 2'b00;
    localparam logic [OPCODE_W-1:0] OP_SUB = 2'b01;
    localparam logic [OPCODE_W-1:0] OP_MUL = 2'b10;
    localparam logic [OPCODE_W-1:0] OP_NOP = 2'b11;

    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [REG_ADDR_W-1:0] dst;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
    } instr_t;

    // One in-flight destination awaiting writeback.
    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
    } sb_entry_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.opcode = w[OPCODE_LSB +: OPCODE_W];
        d.dst    = w[DST_LSB    +: REG_ADDR_W];
        d.src1   = w[SRC1_LSB   +: REG_ADDR_W];
        d.src2   = w[SRC2_LSB   +: REG_ADDR_W];
        return d;
    endfunction

endpackage

// File: rtl/instr_issue_unit_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head, clear, and
// registered occupancy count driving full/empty.
module sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A push while full is refused even if a pop frees a slot this cycle.
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count <= count + 1'b1;
            else if (pop_ok && !push_ok)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/instr_issue_unit.sv
// Instruction issue front end: buffers instruction words, holds back RAW
// hazards against a writeback-latency scoreboard, issues one per cycle.
module instr_issue_unit
    import instr_issue_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WB_LAT     = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [INSTR_W-1:0]    in_instr,
    output logic                  in_ready,
    input  logic                  enable,
    input  logic                  flush,
    output logic                  issue_valid,
    output logic [OPCODE_W-1:0]   opcode,
    output logic [REG_ADDR_W-1:0] src1,
    output logic [REG_ADDR_W-1:0] src2,
    output logic [REG_ADDR_W-1:0] dst,
    output logic [CNT_W-1:0]      issued_count,
    output logic [CNT_W-1:0]      stall_count
);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [INSTR_W-1:0]    head_word;
    instr_t                head;
    logic                  do_pop;
    logic                  do_issue;
    logic                  do_stall;
    logic                  hazard;
    sb_entry_t [WB_LAT-1:0] sb_pipe;

    assign in_ready = !fifo_full;
    assign head     = decode_instr(head_word);

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid && in_ready),
        .pop   (do_pop),
        .clear (flush),
        .din   (in_instr),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_word)
    );

    // Head's own dst is never compared: only older in-flight entries count.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (sb_pipe[i].v && (sb_pipe[i].rd == head.src1 || sb_pipe[i].rd == head.src2))
                hazard = 1'b1;
        end
        if (head.opcode == OP_NOP)
            hazard = 1'b0;
    end

    always_comb begin
        do_pop   = 1'b0;
        do_issue = 1'b0;
        do_stall = 1'b0;
        if (!flush && !fifo_empty && enable) begin
            if (head.opcode == OP_NOP) begin
                do_pop = 1'b1;
            end else if (hazard) begin
                do_stall = 1'b1;
            end else begin
                do_pop   = 1'b1;
                do_issue = 1'b1;
            end
        end
    end

    // Scoreboard keeps shifting through a flush: issued work still writes back.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_pipe <= '0;
        end else begin
            sb_pipe[0].v  <= do_issue;
            sb_pipe[0].rd <= do_issue ? head.dst : '0;
            for (int i = 1; i < WB_LAT; i++)
                sb_pipe[i] <= sb_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid  <= 1'b0;
            opcode       <= OP_NOP;
            src1         <= '0;
            src2         <= '0;
            dst          <= '0;
            issued_count <= '0;
            stall_count  <= '0;
        end else begin
            issue_valid <= do_issue;
            if (do_issue) begin
                opcode       <= head.opcode;
                src1         <= head.src1;
                src2         <= head.src2;
                dst          <= head.dst;
                issued_count <= issued_count + CNT_W'(1);
            end else begin
                opcode <= OP_NOP;
            end
            if (do_stall)
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
